// File: rtl/sdu_line_buf.sv
// Line-assembly stage of the serial debug unit. It edits received bytes into a command line,
// echoes keystrokes back to the transmitter, and presents finished lines for random-access reads.
module sdu_line_buf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned ECHO  = 1,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    d_rx,
  input  logic          vld_rx,
  output logic          rdy_rx,
  output logic [7:0]    d_echo,
  output logic          vld_echo,
  input  logic          rdy_echo,
  output logic          line_vld,
  output logic [AW:0]   line_len,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_char,
  input  logic          line_ack
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);
  localparam bit          ECHO_EN = (ECHO != 0);

  typedef enum logic [1:0] {S_COLLECT, S_ECHO, S_LINE_RDY} state_t;

  state_t      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [23:0] seq_q, seq_d;     // pending echo bytes, next byte in [7:0]
  logic [1:0]  cnt_q, cnt_d;     // echo bytes still to hand over
  logic        to_line_q, to_line_d;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  mem [DEPTH];

  logic is_print, is_lower, is_bs, is_term;

  // Byte classification of the received character
  always_comb begin
    is_print = (d_rx >= 8'h20) && (d_rx <= 8'h7E);
    is_lower = (d_rx >= 8'h61) && (d_rx <= 8'h7A);
    is_bs    = (d_rx == 8'h08) || (d_rx == 8'h7F);
    is_term  = (d_rx == 8'h0D) || (d_rx == 8'h0A);
  end

  // Next-state logic: editing, echo sequencing and line hand-off
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    seq_d     = seq_q;
    cnt_d     = cnt_q;
    to_line_d = to_line_q;
    wr_en     = 1'b0;
    wr_data   = is_lower ? (d_rx - 8'h20) : d_rx;

    case (state_q)
      S_COLLECT: begin
        if (vld_rx) begin
          to_line_d = 1'b0;
          if (is_print) begin
            if (len_q < DEPTH_L) begin
              wr_en = 1'b1;
              len_d = len_q + ONE_L;
              seq_d = {16'h0000, d_rx};
            end else begin
              seq_d = 24'h000007;
            end
            cnt_d = 2'd1;
            if (ECHO_EN) state_d = S_ECHO;
          end else if (is_bs) begin
            if (len_q != '0) begin
              len_d = len_q - ONE_L;
              seq_d = 24'h082008;
              cnt_d = 2'd3;
              if (ECHO_EN) state_d = S_ECHO;
            end
          end else if (is_term) begin
            to_line_d = (len_q != '0);
            seq_d     = 24'h000A0D;
            cnt_d     = 2'd2;
            if (ECHO_EN)           state_d = S_ECHO;
            else if (len_q != '0) state_d = S_LINE_RDY;
          end
        end
      end
      S_ECHO: begin
        if (rdy_echo) begin
          seq_d = {8'h00, seq_q[23:8]};
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = to_line_q ? S_LINE_RDY : S_COLLECT;
        end
      end
      S_LINE_RDY: begin
        if (line_ack) begin
          len_d   = '0;
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_COLLECT;
      len_q     <= '0;
      seq_q     <= '0;
      cnt_q     <= '0;
      to_line_q <= 1'b0;
      rdy_rx    <= 1'b1;
      vld_echo  <= 1'b0;
      d_echo    <= 8'h00;
      line_vld  <= 1'b0;
      line_len  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
      cnt_q     <= cnt_d;
      to_line_q <= to_line_d;
      rdy_rx    <= (state_d == S_COLLECT);
      vld_echo  <= (state_d == S_ECHO);
      d_echo    <= (state_d == S_ECHO) ? seq_d[7:0] : 8'h00;
      line_vld  <= (state_d == S_LINE_RDY);
      line_len  <= (state_d == S_LINE_RDY) ? len_d : '0;
    end
  end

  // Character storage; contents are only visible below line_len, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[len_q[AW-1:0]] <= wr_data;
  end

  assign rd_char = ({1'b0, rd_idx} < line_len) ? mem[rd_idx] : 8'h00;

endmodule

// File: doc/sdu_line_buf.md
# sdu_line_buf

Line-assembly stage of the serial debug unit, sitting between the UART receiver and the debug command processor. Consumes raw received bytes over a valid/ready handshake and edits them into a command line: printable storage with upper-case folding, backspace, full-buffer bell. Echoes each keystroke back toward the UART transmitter. On a CR or LF it presents the finished line to the command processor through random-access read ports.

## Interface
- DEPTH, 32: line buffer capacity in characters; power of two, ≥4. Let AW = $clog2(DEPTH).
- ECHO, 1: 1 = generate echo bytes; 0 = no echo, echo port idle.
- clk  in  1  the divided UART-domain clock, shared with RX/TX/DCP.
- rstn  in  1  reset, asynchronous, active-low.
- d_rx  in  8  received byte.
- vld_rx  in  1  d_rx valid.
- rdy_rx  out  1  block can accept a byte.
- d_echo  out  8  echo byte for the transmitter.
- vld_echo  out  1  d_echo valid.
- rdy_echo  in  1  transmitter accepts d_echo.
- line_vld  out  1  complete line available.
- line_len  out  AW+1  character count of the line, 1..DEPTH.
- rd_idx  in  AW  character index to read.
- rd_char  out  8  buffer[rd_idx]; 0x00 when rd_idx ≥ line_len.
- line_ack  in  1  one-cycle pulse: line consumed, clear buffer.

## Operation
- States: COLLECT, ECHO, LINE_RDY.
- rdy_rx = (state == COLLECT). A byte is taken when vld_rx && rdy_rx.
- Byte classes on accept:
  - Printable 0x20–0x7E:
    - len < DEPTH: store at buffer[len]; a–z (0x61–0x7A) are stored minus 0x20; len++; echo the original byte.
    - len == DEPTH: drop the byte; echo 0x07.
  - Backspace 0x08 or 0x7F:
    - len > 0: len--; echo 0x08, 0x20, 0x08.
    - len == 0: ignore, no echo.
  - Terminator 0x0D or 0x0A: echo 0x0D, 0x0A.
    - len > 0: go to LINE_RDY after the echo.
    - len == 0: return to COLLECT; no line is produced.
  - Any other byte: discarded silently, no echo, stay in COLLECT.
- ECHO state:
  - Sequence length 1–3 held in an internal counter.
  - vld_echo = 1; d_echo holds the current byte until vld_echo && rdy_echo.
  - The next byte appears in the following cycle.
  - After the last handshake: go to LINE_RDY if the terminator had len > 0, else COLLECT.
- ECHO = 0: echo generation is skipped; transitions go directly to the destination state.
- LINE_RDY:
  - line_vld = 1; line_len = len.
  - rd_char is combinational from rd_idx.
  - rdy_rx = 0; incoming bytes stall upstream.
  - On line_ack: len ← 0, state ← COLLECT.
- line_ack outside LINE_RDY is ignored.
- rd_char is masked by rd_idx ≥ line_len in every state. The buffer array is not reset.

## Timing
- Reset values (async, while rstn = 0):
  - state COLLECT, len 0.
  - rdy_rx 1, vld_echo 0, d_echo 0x00.
  - line_vld 0, line_len 0, rd_char 0x00.
- Accept at edge N, ECHO = 1, echo needed:
  - From N+1: vld_echo = 1 and rdy_rx = 0.
  - Minimum occupancy with rdy_echo tied high: 1 cycle per echo byte.
  - rdy_rx returns to 1 the cycle after the final echo handshake.
- ECHO = 0, or no echo needed: rdy_rx stays 1, so one byte is accepted per cycle.
- Terminator with len > 0, accepted at N, ECHO = 0: line_vld = 1 from N+1.
- line_ack sampled at edge M:
  - From M+1: line_vld = 0, line_len = 0, rdy_rx = 1.
- line_ack coincident with the cycle line_vld first rises is honoured.
- rd_char has zero-cycle latency from rd_idx and buffer contents.
- rstn asserted mid-echo or in LINE_RDY: immediate return to the reset values; a partial echo sequence is abandoned.

## Test plan
- ECHO = 1, rdy_echo = 1: send "ab", then 0x0D → echo 0x61, 0x62, 0x0D, 0x0A. Then line_vld = 1, line_len = 2, rd_char(0) = 0x41, rd_char(1) = 0x42, rd_char(2) = 0x00.
- Send "x", 0x08, 0x08, "y", 0x0D:
  - Echo stream: 0x78, 0x08, 0x20, 0x08, 0x79, 0x0D, 0x0A (the second backspace produces no echo).
  - Result: line_len = 1, rd_char(0) = 0x59.
- DEPTH = 4: send "abcde" → fifth byte echoes 0x07; line_len stays 4 after 0x0D.
- Hold rdy_echo = 0 for 10 cycles after sending "q" → vld_echo = 1 and d_echo = 0x71 stable throughout; rdy_rx = 0; no second byte accepted.
- Empty terminator and stall:
  - Bare 0x0D → echo CR LF; line_vld stays 0.
  - In LINE_RDY, assert vld_rx with "z" → rdy_rx = 0 until line_ack; the byte is then accepted as the first character of the new line.
- Reset mid-operation: pulse rstn low during the second echo byte of a backspace sequence → outputs return to reset values immediately; the next "k" gives line_len = 1 after 0x0D.
